parity_lane_scheduler: RTL and testbench

- Shares one 32-bit XOR-fold parity lane among NUM_REQ requesters in the RISC BMI ALU.
- Each request carries a DATA_WIDTH operand. The block arbitrates round-robin, captures the winner's operand, and folds it through the lane one LANE_WIDTH word per cycle.
- Returns the 32-bit folded XOR word, a 1-bit reduction parity, and the requester ID over a valid/ready result port.
- Sits between ALU issue ports and the parity datapath, replacing per-port full-width parity trees.

---
 rtl/parity_sched_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/parity_lane_scheduler.sv | 122 ++++++++++++
 tb/tb_parity_lane_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_sched_pkg.sv
// Shared types and sizing helpers for the parity lane scheduler.
package parity_sched_pkg;

    localparam int DEFAULT_DATA_WIDTH = 256;
    localparam int DEFAULT_LANE_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int beats_of(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

    function automatic int beat_width(input int data_width, input int lane_width);
        return clog2_min1(data_width / lane_width);
    endfunction

    function automatic int id_width(input int num_req);
        return clog2_min1(num_req);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the last winner,
// so the requester served most recently has the lowest priority.
module rr_arbiter
    import parity_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] winner,
    output logic [N-1:0]  grant
);

    logic [IW-1:0] ptr;

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Reset to N-1 so requester 0 is the first candidate.
    always_ff @(posedge clk) begin
        if (rst) ptr <= IW'(N - 1);
        else if (advance) ptr <= winner;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    // Scanning from the farthest offset down lets the nearest valid requester win.
    always_comb begin
        grant = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[wrap(ptr, i)]) begin
                grant = '0;
                grant[wrap(ptr, i)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parity_lane_scheduler.sv
// Shares one LANE_WIDTH XOR-fold lane among NUM_REQ requesters: arbitrate,
// capture the operand, fold one lane word per cycle, then hold the result.
module parity_lane_scheduler
    import parity_sched_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int LANE_WIDTH = DEFAULT_LANE_WIDTH,
    parameter  int NUM_REQ    = 4,
    localparam int IDW        = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [IDW-1:0]                res_id,
    output logic [LANE_WIDTH-1:0]         res_fold,
    output logic                          res_parity,
    output logic                          busy
);

    localparam int BEATS = beats_of(DATA_WIDTH, LANE_WIDTH);
    localparam int BW    = beat_width(DATA_WIDTH, LANE_WIDTH);

    sched_state_t          state, state_next;
    logic [DATA_WIDTH-1:0] operand;
    logic [LANE_WIDTH-1:0] acc;
    logic [BW-1:0]         beat;
    logic [IDW-1:0]        id;

    logic [NUM_REQ-1:0]    grant;
    logic [IDW-1:0]        win_idx;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  accept;
    logic                  last_beat;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .winner  (win_idx),
        .grant   (grant)
    );

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                win_idx  = IDW'(k);
                win_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept    = (state == IDLE) && (|(req_valid & grant));
    assign last_beat = (beat == BW'(BEATS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_beat) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        res_valid  = 1'b0;
        res_fold   = '0;
        res_parity = 1'b0;
        res_id     = '0;
        busy       = (state != IDLE);
        if (state == IDLE) req_ready = grant;
        if (state == DONE) begin
            res_valid  = 1'b1;
            res_fold   = acc;
            res_parity = ^acc;
            res_id     = id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            beat <= '0;
            id   <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    acc  <= '0;
                    beat <= '0;
                    id   <= win_idx;
                end
                RUN: begin
                    acc  <= acc ^ operand[LANE_WIDTH-1:0];
                    beat <= beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the operand is a pure data register, only meaningful after an accept, so it carries no reset.
    // Shifting down one lane per beat keeps the fold input at a fixed bit position.
    always_ff @(posedge clk) begin
        if (accept)             operand <= win_data;
        else if (state == RUN)  operand <= operand >> LANE_WIDTH;
    end

endmodule

// File: tb/tb_parity_lane_scheduler.sv
// Scoreboard bench: an arbitration/fold model predicts every accept and result,
// a negedge monitor compares the DUT against the queued expectations.
module tb_parity_lane_scheduler;

    localparam int DW    = 256;
    localparam int LW    = 32;
    localparam int N     = 4;
    localparam int BEATS = DW / LW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            res_valid;
    logic            res_ready;
    logic [1:0]      res_id;
    logic [LW-1:0]   res_fold;
    logic            res_parity;
    logic            busy;

    logic [DW-1:0]   data_q [N];

    typedef struct {
        int            id;
        logic [LW-1:0] fold;
        logic          par;
        int            due;
    } exp_t;

    exp_t     sb[$];
    int       served_q[$];
    int       acc_cyc[$];
    int       tests = 0;
    int       fails = 0;
    int       cyc = 0;
    int       last_srv = N - 1;
    logic [N-1:0] hs_mask = '0;
    logic [N-1:0] exp_rdy;
    logic         exp_rv;

    parity_lane_scheduler #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_fold   (res_fold),
        .res_parity (res_parity),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_data = '0;
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = data_q[k];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: XOR of all lane words; parity is the operand's ones-count modulo 2.
    function automatic logic [LW-1:0] model_fold(input logic [DW-1:0] d);
        logic [LW-1:0] f;
        f = '0;
        for (int w = 0; w < BEATS; w++) f ^= d[w*LW +: LW];
        return f;
    endfunction

    function automatic logic model_par(input logic [DW-1:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    // Next valid requester after the last one served, wrapping around.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int last);
        logic [N-1:0] r;
        int k;
        r = '0;
        for (int i = 1; i <= N; i++) begin
            k = (last + i) % N;
            if (v[k] && r == '0) r[k] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_operand();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            last_srv = N - 1;
            hs_mask  = '0;
        end else begin
            exp_rdy = (sb.size() == 0) ? rr_pick(req_valid, last_srv) : '0;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("busy", 64'(busy), 64'(sb.size() != 0));
            exp_rv = (sb.size() != 0) && (cyc >= sb[0].due);
            check("res_valid", 64'(res_valid), 64'(exp_rv));
            if (res_valid && exp_rv) begin
                check("res_id", 64'(res_id), 64'(sb[0].id));
                check("res_fold", 64'(res_fold), 64'(sb[0].fold));
                check("res_parity", 64'(res_parity), 64'(sb[0].par));
                if (res_ready) void'(sb.pop_front());
            end
            hs_mask = req_valid & req_ready;
            if (hs_mask != '0 && exp_rdy != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (exp_rdy[k]) begin
                        sb.push_back('{id: k, fold: model_fold(data_q[k]),
                                       par: model_par(data_q[k]), due: cyc + 1 + BEATS});
                        served_q.push_back(k);
                        acc_cyc.push_back(cyc);
                        last_srv = k;
                    end
                end
            end
        end
    end

    // One clock: drop accepted requests, optionally raise new ones with fresh operands.
    task automatic cycle(input int new_pct);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (hs_mask[k]) req_valid[k] = 1'b0;
            if (!req_valid[k] && ($urandom_range(99) < new_pct)) begin
                data_q[k]    = rand_operand();
                req_valid[k] = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        cycle(0);
        rst = 1'b1;
        repeat (n) cycle(0);
        rst = 1'b0;
    endtask

    task automatic wait_res(input string name, input logic [LW-1:0] f, input logic p, input int id);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 * BEATS + 20; i++) begin
            cycle(0);
            @(negedge clk);
            if (res_valid) begin
                found = 1'b1;
                break;
            end
        end
        check({name, "_seen"}, 64'(found), 64'd1);
        if (found) begin
            check({name, "_fold"}, 64'(res_fold), 64'(f));
            check({name, "_par"}, 64'(res_parity), 64'(p));
            check({name, "_id"}, 64'(res_id), 64'(id));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] bp_data;
        int            exp_order [5] = '{0, 1, 2, 3, 0};

        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        for (int k = 0; k < N; k++) data_q[k] = '0;
        repeat (3) cycle(0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_id", 64'(res_id), 64'd0);
        check("rst_res_fold", 64'(res_fold), 64'd0);
        check("rst_res_parity", 64'(res_parity), 64'd0);

        // Directed operands with hand-derived folds.
        cycle(0);
        res_ready    = 1'b1;
        data_q[0]    = 256'h1;
        req_valid[0] = 1'b1;
        wait_res("single", 32'h0000_0001, 1'b1, 0);

        cycle(0);
        data_q[0]    = '1;
        req_valid[0] = 1'b1;
        wait_res("all_ones", 32'h0000_0000, 1'b0, 0);

        cycle(0);
        data_q[1]    = {32'h0000_000F, 192'h0, 32'hA5A5_A5A5};
        req_valid[1] = 1'b1;
        wait_res("a5_pattern", 32'hA5A5_A5AA, 1'b0, 1);

        // Contention: all requesters held valid from reset.
        do_reset(2);
        served_q.delete();
        acc_cyc.delete();
        res_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            data_q[k]    = rand_operand();
            req_valid[k] = 1'b1;
        end
        repeat (5 * (BEATS + 2) + 2) cycle(100);
        check("rr_count", 64'(served_q.size() >= 5), 64'd1);
        for (int i = 0; i < 5 && i < served_q.size(); i++)
            check("rr_order", 64'(served_q[i]), 64'(exp_order[i]));
        for (int i = 1; i < 5 && i < acc_cyc.size(); i++)
            check("rr_period", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(BEATS + 2));
        req_valid = '0;
        repeat (2 * (BEATS + 2)) cycle(0);

        // Backpressure: result held in DONE while a second request waits.
        do_reset(2);
        res_ready    = 1'b0;
        bp_data      = rand_operand();
        data_q[0]    = bp_data;
        req_valid[0] = 1'b1;
        wait_res("bp_first", model_fold(bp_data), model_par(bp_data), 0);
        cycle(0);
        data_q[1]    = rand_operand();
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(res_valid), 64'd1);
            check("bp_hold_fold", 64'(res_fold), 64'(model_fold(bp_data)));
            check("bp_hold_id", 64'(res_id), 64'd0);
            check("bp_hold_ready", 64'(req_ready), 64'd0);
            cycle(0);
        end
        res_ready = 1'b1;
        cycle(0);
        @(negedge clk);
        check("bp_release_valid", 64'(res_valid), 64'd0);
        check("bp_release_grant", 64'(req_ready), 64'b0010);
        cycle(0);
        @(negedge clk);
        check("bp_req1_busy", 64'(busy), 64'd1);
        repeat (BEATS + 4) cycle(0);

        // Operand isolation: the source changes right after accept.
        do_reset(2);
        res_ready    = 1'b1;
        bp_data      = rand_operand();
        data_q[0]    = bp_data;
        req_valid[0] = 1'b1;
        cycle(0);
        cycle(0);
        data_q[0] = '1;
        wait_res("isolation", model_fold(bp_data), model_par(bp_data), 0);

        // Reset in the middle of RUN discards the in-flight result.
        do_reset(2);
        res_ready    = 1'b1;
        data_q[2]    = rand_operand();
        req_valid[2] = 1'b1;
        cycle(0);
        repeat (5) cycle(0);
        data_q[0]    = rand_operand();
        data_q[2]    = rand_operand();
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        rst          = 1'b1;
        cycle(0);
        rst = 1'b0;
        served_q.delete();
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_res_valid", 64'(res_valid), 64'd0);
        cycle(0);
        check("midrst_first_grant", 64'(served_q.size() > 0 ? served_q[0] : -1), 64'd0);
        repeat (3 * (BEATS + 2)) cycle(0);

        // Randomised traffic with random backpressure.
        do_reset(2);
        for (int i = 0; i < 1500; i++) begin
            res_ready = ($urandom_range(99) < 60);
            cycle(35);
        end
        res_ready = 1'b1;
        repeat (N * (BEATS + 2) + 20) cycle(0);
        check("drain_scoreboard", 64'(sb.size()), 64'd0);
        check("drain_requests", 64'(req_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
